// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Two-requester read arbiter in front of a single AXI read adapter. Requester
// 0 is the DMA engine, requester 1 is the accelerator (XCEL). One burst is
// owned end to end: the granted requester's address phase is forwarded, then
// exactly len+1 data beats are routed back to it before the next arbitration.
// Ties are broken round-robin against the last requester that was served.
//
// Parameters
//   AXI_AWIDTH               address width
//   AXI_DWIDTH               data width
//
// Ports
//   clk                      sole clock, rising edge
//   resetn                   asynchronous active-low reset
//   req_read_request_valid   [1:0] request valid per requester (0=DMA,1=XCEL)
//   req_read_request_ready   [1:0] request accepted per requester
//   req_read_addr            [2*AXI_AWIDTH-1:0] packed start addresses
//   req_read_len             [63:0] packed 32-bit lengths (beats - 1)
//   req_read_size            [5:0]  packed 3-bit AXI size
//   req_read_burst           [3:0]  packed 2-bit AXI burst type
//   req_read_data            [AXI_DWIDTH-1:0] read data, broadcast
//   req_read_data_valid      [1:0] data valid per requester
//   req_read_data_ready      [1:0] data ready per requester
//   core_read_request_valid  request valid to the adapter
//   core_read_request_ready  adapter accepted the request
//   core_read_addr/len/size/burst  forwarded request fields (0 outside ADDR)
//   core_read_data           adapter read data
//   core_read_data_valid     adapter data valid
//   core_read_data_ready     data ready to the adapter
//   busy                     high whenever the arbiter is not idle
//   owner                    index of the currently granted requester
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [1:0]                req_read_request_valid,
  output logic [1:0]                req_read_request_ready,
  input  logic [2*AXI_AWIDTH-1:0]   req_read_addr,
  input  logic [63:0]               req_read_len,
  input  logic [5:0]                req_read_size,
  input  logic [3:0]                req_read_burst,
  output logic [AXI_DWIDTH-1:0]     req_read_data,
  output logic [1:0]                req_read_data_valid,
  input  logic [1:0]                req_read_data_ready,
  output logic                      core_read_request_valid,
  input  logic                      core_read_request_ready,
  output logic [AXI_AWIDTH-1:0]     core_read_addr,
  output logic [31:0]               core_read_len,
  output logic [2:0]                core_read_size,
  output logic [1:0]                core_read_burst,
  input  logic [AXI_DWIDTH-1:0]     core_read_data,
  input  logic                      core_read_data_valid,
  output logic                      core_read_data_ready,
  output logic                      busy,
  output logic                      owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Places a single-bit value on the lane of the given requester, zero on the
  // other lane, so the non-owner never sees a ready or valid.
  function automatic logic [1:0] lane_of(input logic sel, input logic val);
    logic [1:0] res;
    if (sel) begin
      res = {val, 1'b0};
    end else begin
      res = {1'b0, val};
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        owner_r;
  logic        owner_nxt_s;
  logic        last_r;
  logic        last_nxt_s;
  logic [31:0] len_q_r;
  logic [31:0] len_q_nxt_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_nxt_s;

  // Fields of the currently owned requester.
  logic                  own_valid_s;
  logic                  own_dready_s;
  logic [AXI_AWIDTH-1:0] own_addr_s;
  logic [31:0]           own_len_s;
  logic [2:0]            own_size_s;
  logic [1:0]            own_burst_s;
  logic                  beat_s;

  // Select the owner's request fields from the packed buses.
  always_comb begin
    if (owner_r) begin
      own_valid_s  = req_read_request_valid[1];
      own_dready_s = req_read_data_ready[1];
      own_addr_s   = req_read_addr[2*AXI_AWIDTH-1:AXI_AWIDTH];
      own_len_s    = req_read_len[63:32];
      own_size_s   = req_read_size[5:3];
      own_burst_s  = req_read_burst[3:2];
    end else begin
      own_valid_s  = req_read_request_valid[0];
      own_dready_s = req_read_data_ready[0];
      own_addr_s   = req_read_addr[AXI_AWIDTH-1:0];
      own_len_s    = req_read_len[31:0];
      own_size_s   = req_read_size[2:0];
      own_burst_s  = req_read_burst[1:0];
    end
  end

  assign beat_s = core_read_data_valid & own_dready_s;

  // State and bookkeeping registers; reset makes DMA win the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
      len_q_r <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
      len_q_r <= len_q_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic and the combinational routing of both handshakes.
  always_comb begin
    state_nxt_s             = state_r;
    owner_nxt_s             = owner_r;
    last_nxt_s              = last_r;
    len_q_nxt_s             = len_q_r;
    cnt_nxt_s               = cnt_r;
    req_read_request_ready  = 2'b00;
    req_read_data           = {AXI_DWIDTH{1'b0}};
    req_read_data_valid     = 2'b00;
    core_read_request_valid = 1'b0;
    core_read_addr          = {AXI_AWIDTH{1'b0}};
    core_read_len           = 32'd0;
    core_read_size          = 3'd0;
    core_read_burst         = 2'd0;
    core_read_data_ready    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req_read_request_valid == 2'b11) begin
          owner_nxt_s = ~last_r;
          state_nxt_s = ST_ADDR;
        end else if (req_read_request_valid != 2'b00) begin
          owner_nxt_s = req_read_request_valid[1];
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        core_read_request_valid = own_valid_s;
        core_read_addr          = own_addr_s;
        core_read_len           = own_len_s;
        core_read_size          = own_size_s;
        core_read_burst         = own_burst_s;
        req_read_request_ready  = lane_of(owner_r, core_read_request_ready);
        if (!own_valid_s) begin
          // Owner withdrew before the adapter took it: drop the grant.
          state_nxt_s = ST_IDLE;
        end else if (core_read_request_ready) begin
          len_q_nxt_s = own_len_s;
          cnt_nxt_s   = 32'd0;
          last_nxt_s  = owner_r;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end

      ST_DATA: begin
        req_read_data        = core_read_data;
        req_read_data_valid  = lane_of(owner_r, core_read_data_valid);
        core_read_data_ready = own_dready_s;
        if (beat_s) begin
          if (cnt_r == len_q_r) begin
            // Final beat: no increment, so len 0xFFFFFFFF never wraps cnt.
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s   = cnt_r + 32'd1;
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign busy  = (state_r != ST_IDLE);
  assign owner = owner_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            resetn;
  logic [1:0]      req_read_request_valid;
  logic [1:0]      req_read_request_ready;
  logic [2*AW-1:0] req_read_addr;
  logic [63:0]     req_read_len;
  logic [5:0]      req_read_size;
  logic [3:0]      req_read_burst;
  logic [DW-1:0]   req_read_data;
  logic [1:0]      req_read_data_valid;
  logic [1:0]      req_read_data_ready;
  logic            core_read_request_valid;
  logic            core_read_request_ready;
  logic [AW-1:0]   core_read_addr;
  logic [31:0]     core_read_len;
  logic [2:0]      core_read_size;
  logic [1:0]      core_read_burst;
  logic [DW-1:0]   core_read_data;
  logic            core_read_data_valid;
  logic            core_read_data_ready;
  logic            busy;
  logic            owner;

  int tests_run;
  int tests_failed;

  logic [108:0] all_out;
  assign all_out = {req_read_request_ready, req_read_data, req_read_data_valid,
                    core_read_request_valid, core_read_addr, core_read_len,
                    core_read_size, core_read_burst, core_read_data_ready,
                    busy, owner};

  axi_rd_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .req_read_request_valid  (req_read_request_valid),
    .req_read_request_ready  (req_read_request_ready),
    .req_read_addr           (req_read_addr),
    .req_read_len            (req_read_len),
    .req_read_size           (req_read_size),
    .req_read_burst          (req_read_burst),
    .req_read_data           (req_read_data),
    .req_read_data_valid     (req_read_data_valid),
    .req_read_data_ready     (req_read_data_ready),
    .core_read_request_valid (core_read_request_valid),
    .core_read_request_ready (core_read_request_ready),
    .core_read_addr          (core_read_addr),
    .core_read_len           (core_read_len),
    .core_read_size          (core_read_size),
    .core_read_burst         (core_read_burst),
    .core_read_data          (core_read_data),
    .core_read_data_valid    (core_read_data_valid),
    .core_read_data_ready    (core_read_data_ready),
    .busy                    (busy),
    .owner                   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_read_request_valid  = 2'b00;
    req_read_addr           = 64'd0;
    req_read_len            = 64'd0;
    req_read_size           = 6'd0;
    req_read_burst          = 4'd0;
    req_read_data_ready     = 2'b00;
    core_read_request_ready = 1'b0;
    core_read_data          = 32'd0;
    core_read_data_valid    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_read_request_valid  = 2'($urandom_range(3, 0));
      req_read_addr           = {$urandom, $urandom};
      req_read_len            = {$urandom, $urandom};
      req_read_size           = 6'($urandom_range(63, 0));
      req_read_burst          = 4'($urandom_range(15, 0));
      req_read_data_ready     = 2'($urandom_range(3, 0));
      core_read_request_ready = 1'($urandom_range(1, 0));
      core_read_data          = $urandom;
      core_read_data_valid    = 1'($urandom_range(1, 0));
      tick();
      tests_run++;
      if (all_out !== 109'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_busy: got %b expected 0", busy);
      end
    end
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_dma_single();
    int beats;
    req_read_request_valid  = 2'b01;
    req_read_addr           = {32'h0000_9999, 32'h0000_1000};
    req_read_len            = {32'd5, 32'd3};
    req_read_size           = {3'd1, 3'd2};
    req_read_burst          = {2'd0, 2'd1};
    req_read_data_ready     = 2'b11;
    #1;
    tests_run++;
    if (core_read_request_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL dma_latency_t0: core valid %b expected 0", core_read_request_valid);
    end
    tick();
    tests_run++;
    if ({core_read_request_valid, core_read_addr, core_read_len, core_read_size,
         core_read_burst, owner, req_read_request_ready} !==
        {1'b1, 32'h0000_1000, 32'd3, 3'd2, 2'd1, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL dma_addr_phase: valid %b addr %h len %0d size %0d burst %0d owner %b rdy %b expected 1 1000 3 2 1 0 00",
               core_read_request_valid, core_read_addr, core_read_len, core_read_size,
               core_read_burst, owner, req_read_request_ready);
    end
    core_read_request_ready = 1'b1;
    #1;
    tests_run++;
    if (req_read_request_ready !== 2'b01) begin
      tests_failed++;
      $display("FAIL dma_req_ready: got %b expected 01", req_read_request_ready);
    end
    tick();
    req_read_request_valid  = 2'b00;
    core_read_request_ready = 1'b0;
    #1;
    tests_run++;
    if (core_read_addr !== 32'd0 || core_read_len !== 32'd0) begin
      tests_failed++;
      $display("FAIL dma_addr_outside: addr %h len %h expected 0 0", core_read_addr, core_read_len);
    end
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      core_read_data       = 32'hA0 + 32'(i);
      core_read_data_valid = 1'b1;
      #1;
      tests_run++;
      if (req_read_data_valid !== 2'b01 || req_read_data !== 32'hA0 + 32'(i) ||
          core_read_data_ready !== 1'b1 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL dma_beat%0d: dv %b data %h crdy %b busy %b expected 01 %h 1 1",
                 i, req_read_data_valid, req_read_data, core_read_data_ready, busy, 32'hA0 + 32'(i));
      end else begin
        beats++;
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || req_read_data_valid !== 2'b00 || core_read_data_ready !== 1'b0 || owner !== 1'b0) begin
      tests_failed++;
      $display("FAIL dma_done: busy %b dv %b crdy %b owner %b expected 0 00 0 0",
               busy, req_read_data_valid, core_read_data_ready, owner);
    end
    tests_run++;
    if (beats != 4) begin
      tests_failed++;
      $display("FAIL dma_beat_count: got %0d expected 4", beats);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    int grants;
    int beats;
    logic exp_own;
    resetn = 1'b0;
    #2;
    @(negedge clk);
    resetn = 1'b1;
    req_read_request_valid  = 2'b11;
    req_read_len            = 64'd0;
    req_read_data_ready     = 2'b11;
    core_read_request_ready = 1'b1;
    core_read_data_valid    = 1'b1;
    grants = 0;
    beats  = 0;
    exp_own = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (core_read_request_valid === 1'b1) begin
        exp_own = grants[0];
        tests_run++;
        if (owner !== exp_own || req_read_request_ready !== (exp_own ? 2'b10 : 2'b01)) begin
          tests_failed++;
          $display("FAIL rr_grant%0d: owner %b rdy %b expected %b %b", grants, owner,
                   req_read_request_ready, exp_own, (exp_own ? 2'b10 : 2'b01));
        end
        grants++;
      end
      if (req_read_data_valid !== 2'b00) begin
        tests_run++;
        if (req_read_data_valid !== (exp_own ? 2'b10 : 2'b01)) begin
          tests_failed++;
          $display("FAIL rr_data_route: dv %b expected %b", req_read_data_valid, (exp_own ? 2'b10 : 2'b01));
        end
        beats++;
      end
    end
    tests_run++;
    if (grants != 4 || beats != 4) begin
      tests_failed++;
      $display("FAIL rr_counts: grants %0d beats %0d expected 4 4", grants, beats);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    int beats;
    req_read_request_valid  = 2'b01;
    req_read_addr           = {32'd0, 32'h0000_2000};
    req_read_len            = {32'd0, 32'd7};
    core_read_request_ready = 1'b1;
    tick();
    tick();
    req_read_request_valid  = 2'b00;
    core_read_request_ready = 1'b0;
    core_read_data_valid    = 1'b1;
    beats = 0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      req_read_data_ready = {1'b1, c[0]};
      core_read_data      = 32'(beats);
      #1;
      tests_run++;
      if (core_read_data_ready !== c[0] || req_read_data_valid !== 2'b01) begin
        tests_failed++;
        $display("FAIL bp_mirror_c%0d: crdy %b dv %b expected %b 01", c,
                 core_read_data_ready, req_read_data_valid, c[0]);
      end
      if (core_read_data_ready === 1'b1) begin
        tests_run++;
        if (req_read_data !== 32'(beats)) begin
          tests_failed++;
          $display("FAIL bp_data: got %h expected %h", req_read_data, 32'(beats));
        end
        beats++;
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || beats != 8) begin
      tests_failed++;
      $display("FAIL bp_total: busy %b beats %0d expected 0 8", busy, beats);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_contention();
    req_read_request_valid  = 2'b01;
    req_read_addr           = {32'h0000_3000, 32'h0000_4000};
    req_read_len            = {32'd0, 32'd2};
    req_read_data_ready     = 2'b11;
    core_read_request_ready = 1'b1;
    core_read_data_valid    = 1'b1;
    tick();
    tick();
    req_read_request_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (req_read_request_ready !== 2'b00 || core_read_request_valid !== 1'b0 ||
          req_read_data_valid !== 2'b01) begin
        tests_failed++;
        $display("FAIL cont_dma_data%0d: rdy %b cvalid %b dv %b expected 00 0 01", i,
                 req_read_request_ready, core_read_request_valid, req_read_data_valid);
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || req_read_request_ready !== 2'b00) begin
      tests_failed++;
      $display("FAIL cont_idle_gap: busy %b rdy %b expected 0 00", busy, req_read_request_ready);
    end
    tick();
    tests_run++;
    if (owner !== 1'b1 || core_read_request_valid !== 1'b1 || req_read_request_ready !== 2'b10 ||
        core_read_addr !== 32'h0000_3000) begin
      tests_failed++;
      $display("FAIL cont_xcel_grant: owner %b cvalid %b rdy %b addr %h expected 1 1 10 3000",
               owner, core_read_request_valid, req_read_request_ready, core_read_addr);
    end
    tick();
    req_read_request_valid = 2'b00;
    #1;
    tests_run++;
    if (req_read_data_valid !== 2'b10) begin
      tests_failed++;
      $display("FAIL cont_xcel_data: dv %b expected 10", req_read_data_valid);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cont_xcel_done: busy %b expected 0", busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_abort();
    req_read_request_valid = 2'b01;
    req_read_addr          = {32'd0, 32'h0000_5000};
    tick();
    tests_run++;
    if (core_read_request_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_addr: cvalid %b expected 1", core_read_request_valid);
    end
    req_read_request_valid = 2'b00;
    #1;
    tests_run++;
    if (core_read_request_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_drop: cvalid %b expected 0", core_read_request_valid);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || core_read_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_idle: busy %b addr %h expected 0 0", busy, core_read_addr);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int beats;
    req_read_request_valid  = 2'b01;
    req_read_len            = {32'd0, 32'd3};
    req_read_data_ready     = 2'b01;
    core_read_request_ready = 1'b1;
    core_read_data_valid    = 1'b1;
    tick();
    tick();
    req_read_request_valid = 2'b00;
    tick();
    tick();
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || req_read_data_valid !== 2'b00 || core_read_data_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_abandon: busy %b dv %b crdy %b expected 0 00 0",
               busy, req_read_data_valid, core_read_data_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b0 || req_read_data_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: busy %b dv %b expected 0 00", busy, req_read_data_valid);
    end
    req_read_request_valid = 2'b01;
    req_read_len           = {32'd0, 32'd1};
    tick();
    tick();
    req_read_request_valid = 2'b00;
    beats = 0;
    for (int c = 0; c < 10 && busy === 1'b1; c++) begin
      if (req_read_data_valid === 2'b01 && core_read_data_ready === 1'b1) begin
        beats++;
      end
      tick();
    end
    tests_run++;
    if (busy !== 1'b0 || beats != 2) begin
      tests_failed++;
      $display("FAIL rst_mid_next: busy %b beats %0d expected 0 2", busy, beats);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    clear_inputs();
    test_reset();
    test_dma_single();
    test_round_robin();
    test_backpressure();
    test_contention();
    test_abort();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
